mem_stage: RTL and testbench

//  MIPS pipeline MEM stage, directly downstream of ex_stage, upstream of the writeback stage.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_stage.sv | 117 +++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, payload layouts and FSM encoding for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned ES_TO_MS_BUS_WD = 71;
  localparam int unsigned MS_TO_WS_BUS_WD = 70;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } ms_state_e;

  // EX->MEM payload: {pc, load_op, rf_we, rf_waddr, alu_result}
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            load_op;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] alu_result;
  } es_to_ms_t;

  // MEM->WB payload: {pc, rf_we, rf_waddr, final_result}
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] final_result;
  } ms_to_ws_t;

endpackage

// File: rtl/mem_stage.sv
// MIPS MEM stage: registers the EX payload, waits for the load response,
// selects the final result and offers it to WB plus bypass info to decode.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       cpu_data_data_ok,
  input  logic [XLEN-1:0]            cpu_data_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ms_valid,
  output logic                       ms_rf_we,
  output logic [4:0]                 ms_rf_waddr,
  output logic                       ms_fwd_valid,
  output logic [XLEN-1:0]            ms_fwd_data,
  output logic                       ms_data_err
);

  ms_state_e       state_q, state_d;
  es_to_ms_t       bus_q;
  es_to_ms_t       bus_in;
  ms_to_ws_t       ws_bus;
  logic [XLEN-1:0] ld_buf_q;
  logic            data_err_q;
  logic            in_wait;
  logic            ms_ready_go;
  logic            accept;
  logic [XLEN-1:0] final_result;

  // Handshake and result selection
  always_comb begin
    bus_in       = es_to_ms_t'(es_to_ms_bus);
    in_wait      = (state_q == StWait);
    ms_valid     = (state_q != StEmpty);
    ms_ready_go  = (state_q == StReady) | (in_wait & cpu_data_data_ok);
    ms_allowin   = ~ms_valid | (ms_ready_go & ws_allowin);
    accept       = ms_allowin & es_to_ms_valid;
    // Same-cycle response bypasses ld_buf
    if (bus_q.load_op) begin
      final_result = in_wait ? cpu_data_rdata : ld_buf_q;
    end else begin
      final_result = bus_q.alu_result;
    end
  end

  // Next-state: whenever MEM can accept, the new occupant (or nothing) decides the state
  always_comb begin
    state_d = state_q;
    if (ms_allowin) begin
      if (accept) begin
        state_d = bus_in.load_op ? StWait : StReady;
      end else begin
        state_d = StEmpty;
      end
    end else if (in_wait && cpu_data_data_ok) begin
      // Response arrived while WB is stalled: park it in ld_buf
      state_d = StReady;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // EX->MEM payload register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q <= '0;
    end else if (accept) begin
      bus_q <= bus_in;
    end
  end

  // Load data buffer, captured on the response strobe while waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_buf_q <= '0;
    end else if (in_wait && cpu_data_data_ok) begin
      ld_buf_q <= cpu_data_rdata;
    end
  end

  // Sticky error for a response with no load waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_err_q <= 1'b0;
    end else if (cpu_data_data_ok && !in_wait) begin
      data_err_q <= 1'b1;
    end
  end

  // Output packing
  always_comb begin
    ws_bus.pc           = bus_q.pc;
    ws_bus.rf_we        = bus_q.rf_we;
    ws_bus.rf_waddr     = bus_q.rf_waddr;
    ws_bus.final_result = final_result;
    ms_to_ws_bus        = ws_bus;
    ms_to_ws_valid      = ms_valid & ms_ready_go;
    ms_rf_we            = ms_valid & bus_q.rf_we;
    ms_rf_waddr         = bus_q.rf_waddr;
    ms_fwd_valid        = ms_valid & bus_q.rf_we & ms_ready_go;
    ms_fwd_data         = final_result;
    ms_data_err         = data_err_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, async reset corner
// cases, then randomized traffic against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [70:0] es_to_ms_bus;
  logic        cpu_data_data_ok;
  logic [31:0] cpu_data_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        ms_valid;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic        ms_fwd_valid;
  logic [31:0] ms_fwd_data;
  logic        ms_data_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .cpu_data_data_ok (cpu_data_data_ok),
    .cpu_data_rdata   (cpu_data_rdata),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ms_valid         (ms_valid),
    .ms_rf_we         (ms_rf_we),
    .ms_rf_waddr      (ms_rf_waddr),
    .ms_fwd_valid     (ms_fwd_valid),
    .ms_fwd_data      (ms_fwd_data),
    .ms_data_err      (ms_data_err)
  );

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        ev;
    logic        ld;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic        wsa;
    logic        dok;
    logic [31:0] rd;
    logic        e_allow;
    logic        e_tows;
    logic        e_fwd;
    logic [31:0] e_res;
  } vec_t;

  function automatic vec_t mk(input logic ev, input logic ld, input logic we, input logic [4:0] wa,
                              input logic [31:0] alu, input logic wsa, input logic dok,
                              input logic [31:0] rd, input logic e_allow, input logic e_tows,
                              input logic e_fwd, input logic [31:0] e_res);
    vec_t v;
    v.ev = ev; v.ld = ld; v.we = we; v.wa = wa; v.alu = alu; v.wsa = wsa; v.dok = dok;
    v.rd = rd; v.e_allow = e_allow; v.e_tows = e_tows; v.e_fwd = e_fwd; v.e_res = e_res;
    return v;
  endfunction

  task automatic drive(input logic ev, input logic [31:0] pc, input logic ld, input logic we,
                       input logic [4:0] wa, input logic [31:0] alu, input logic wsa,
                       input logic dok, input logic [31:0] rd);
    es_to_ms_valid   = ev;
    es_to_ms_bus     = {pc, ld, we, wa, alu};
    ws_allowin       = wsa;
    cpu_data_data_ok = dok;
    cpu_data_rdata   = rd;
  endtask

  // Reference model: one instruction slot plus "response received" flag
  logic        m_occ, m_ld, m_we, m_got, m_err;
  logic [4:0]  m_wa;
  logic [31:0] m_pc, m_alu, m_data;

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("reset_ms_valid", 70'(ms_valid), 70'd0);
    chk("reset_to_ws_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("reset_rf_we", 70'(ms_rf_we), 70'd0);
    chk("reset_fwd_valid", 70'(ms_fwd_valid), 70'd0);
    chk("reset_data_err", 70'(ms_data_err), 70'd0);
    chk("reset_bus", ms_to_ws_bus, 70'd0);
    @(negedge clk);
    reset = 1'b0;

    //           ev ld we wa     alu            wsa dok rd            allow tows fwd res
    // 1: non-load
    vecs.push_back(mk(1, 0, 1, 5'd5, 32'h1234, 1, 0, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,    1, 0, 32'h0,        1, 1, 1, 32'h1234));
    // 2: load, zero-wait response
    vecs.push_back(mk(1, 1, 1, 5'd6, 32'h40,   1, 0, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,    1, 1, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF));
    // 3: load, response 3 cycles late, next (non-load, no rf_we) held upstream
    vecs.push_back(mk(1, 1, 1, 5'd7, 32'h0,    1, 0, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 5'd8, 32'h55,   1, 0, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 5'd8, 32'h55,   1, 0, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 5'd8, 32'h55,   1, 0, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 5'd8, 32'h55,   1, 1, 32'hCAFEF00D, 1, 1, 1, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,    1, 0, 32'h0,        1, 1, 0, 32'h55));
    // 4: response while WB stalled for 2 cycles
    vecs.push_back(mk(1, 1, 1, 5'd9, 32'h0,    1, 0, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,    0, 1, 32'h13579BDF, 0, 1, 1, 32'h13579BDF));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,    0, 0, 32'hFFFFFFFF, 0, 1, 1, 32'h13579BDF));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,    1, 0, 32'hFFFFFFFF, 1, 1, 1, 32'h13579BDF));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,    1, 0, 32'h0,        1, 0, 0, 32'h0));
    // 5: back-to-back load, non-load, load
    vecs.push_back(mk(1, 1, 1, 5'd10, 32'h0,   1, 0, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 1, 5'd11, 32'h77,  1, 1, 32'h11111111, 1, 1, 1, 32'h11111111));
    vecs.push_back(mk(1, 1, 1, 5'd12, 32'h0,   1, 0, 32'h0,        1, 1, 1, 32'h77));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,    1, 1, 32'h22222222, 1, 1, 1, 32'h22222222));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,    1, 0, 32'h0,        1, 0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ev, 32'h1000 + 32'(i * 4), vecs[i].ld, vecs[i].we, vecs[i].wa, vecs[i].alu,
            vecs[i].wsa, vecs[i].dok, vecs[i].rd);
      #2;
      chk($sformatf("vec%0d_allowin", i), 70'(ms_allowin), 70'(vecs[i].e_allow));
      chk($sformatf("vec%0d_to_ws_valid", i), 70'(ms_to_ws_valid), 70'(vecs[i].e_tows));
      chk($sformatf("vec%0d_fwd_valid", i), 70'(ms_fwd_valid), 70'(vecs[i].e_fwd));
      chk($sformatf("vec%0d_data_err", i), 70'(ms_data_err), 70'd0);
      if (vecs[i].e_tows) begin
        chk($sformatf("vec%0d_result", i), 70'(ms_to_ws_bus[31:0]), 70'(vecs[i].e_res));
      end
    end

    // 6a: spurious response in EMPTY sets a sticky error
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'hABCD);
    #2;
    chk("spurious_not_taken", 70'(ms_to_ws_valid), 70'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
      #2;
      chk($sformatf("err_sticky%0d", i), 70'(ms_data_err), 70'd1);
    end
    // 6b: async reset in the middle of a load wait
    @(negedge clk);
    drive(1'b1, 32'h2000, 1'b1, 1'b1, 5'd3, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    #2;
    chk("pre_reset_waiting", 70'(ms_rf_we), 70'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_ms_valid", 70'(ms_valid), 70'd0);
    chk("async_rst_to_ws_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("async_rst_rf_we", 70'(ms_rf_we), 70'd0);
    chk("async_rst_fwd_valid", 70'(ms_fwd_valid), 70'd0);
    chk("async_rst_data_err", 70'(ms_data_err), 70'd0);
    chk("async_rst_bus", ms_to_ws_bus, 70'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the reference model
    begin
      logic        have, ev, ld, we, wsa, dok;
      logic [4:0]  wa;
      logic [31:0] pc, alu, rd, e_res;
      logic        m_ready, m_allow;
      m_occ = 0; m_ld = 0; m_we = 0; m_got = 0; m_err = 0;
      m_wa = 0; m_pc = 0; m_alu = 0; m_data = 0;
      have = 0; ld = 0; we = 0; wa = 0; pc = 0; alu = 0;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        if (!have && ($urandom % 10 < 7)) begin
          have = 1;
          ld   = 1'($urandom % 2);
          we   = 1'($urandom % 4 != 0);
          wa   = 5'($urandom);
          pc   = $urandom;
          alu  = $urandom;
        end
        ev  = have;
        wsa = 1'($urandom % 10 < 7);
        dok = m_occ && m_ld && !m_got && ($urandom % 3 == 0);
        rd  = $urandom;
        drive(ev, pc, ld, we, wa, alu, wsa, dok, rd);
        m_ready = m_occ && (!m_ld || m_got || dok);
        m_allow = !m_occ || (m_ready && wsa);
        e_res   = m_ld ? (m_got ? m_data : rd) : m_alu;
        #2;
        chk("rnd_allowin", 70'(ms_allowin), 70'(m_allow));
        chk("rnd_to_ws_valid", 70'(ms_to_ws_valid), 70'(m_ready));
        chk("rnd_ms_valid", 70'(ms_valid), 70'(m_occ));
        chk("rnd_rf_we", 70'(ms_rf_we), 70'(m_occ && m_we));
        chk("rnd_fwd_valid", 70'(ms_fwd_valid), 70'(m_ready && m_we));
        chk("rnd_data_err", 70'(ms_data_err), 70'(m_err));
        if (m_ready) begin
          chk("rnd_ws_bus", ms_to_ws_bus, {m_pc, m_we, m_wa, e_res});
          chk("rnd_fwd_data", 70'(ms_fwd_data), 70'(e_res));
        end
        if (m_occ) chk("rnd_rf_waddr", 70'(ms_rf_waddr), 70'(m_wa));
        @(posedge clk);
        if (dok) begin
          m_got  = 1;
          m_data = rd;
        end
        if (m_allow) begin
          m_occ = ev;
          if (ev) begin
            m_pc = pc; m_ld = ld; m_we = we; m_wa = wa; m_alu = alu; m_got = 0;
            have = 0;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
